// File: rtl/riscv_pc_unit_if.sv
// Control-flow bus between execute and the PC unit.
// The execute stage (master) drives the selects and the ALU data; the PC unit (slave) returns
// the PC, the link value and the trap/CSR state.
interface riscv_pc_unit_if;
  logic        en_i;
  logic        branch_i;
  logic        jal_i;
  logic        jalr_i;
  logic [31:0] imm_i;
  logic        alu_flag_i;
  logic [31:0] alu_result_i;
  logic        trap_ack_i;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        taken_o;
  logic        trap_o;
  logic [31:0] mepc_o;
  logic [31:0] mtval_o;
  logic [31:0] instret_o;

  modport master (
    output en_i, branch_i, jal_i, jalr_i, imm_i, alu_flag_i, alu_result_i, trap_ack_i,
    input  pc_o, pc_plus4_o, taken_o, trap_o, mepc_o, mtval_o, instret_o
  );

  modport slave (
    input  en_i, branch_i, jal_i, jalr_i, imm_i, alu_flag_i, alu_result_i, trap_ack_i,
    output pc_o, pc_plus4_o, taken_o, trap_o, mepc_o, mtval_o, instret_o
  );
endinterface

// File: rtl/riscv_pc_unit.sv
// Program counter / control-flow stage. Picks the next PC from the instruction in execute,
// traps on misaligned redirect targets and counts retired instructions.
module riscv_pc_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input logic             clk_i,
  input logic             rst_i,
  riscv_pc_unit_if.slave  bus
);

  typedef enum logic [0:0] {StRun, StTrap} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] mepc_q;
  logic [31:0] mtval_q;
  logic [31:0] instret_q;
  logic        taken_q;

  logic [31:0] tgt;
  logic        redirect;
  logic        misaligned;

  // Target select: jalr beats jal beats a taken branch beats fall-through.
  always_comb begin
    tgt      = pc_q + 32'd4;
    redirect = 1'b0;
    if (bus.jalr_i) begin
      tgt      = bus.alu_result_i & 32'hFFFF_FFFE;
      redirect = 1'b1;
    end else if (bus.jal_i) begin
      tgt      = pc_q + bus.imm_i;
      redirect = 1'b1;
    end else if (bus.branch_i && bus.alu_flag_i) begin
      tgt      = pc_q + bus.imm_i;
      redirect = 1'b1;
    end
    // Fall-through is always word aligned, so only redirects are checked.
    misaligned = redirect && (tgt[1:0] != 2'b00);
  end

  // Run/trap FSM together with the PC and CSR-like registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StRun;
      pc_q      <= RESET_VECTOR;
      taken_q   <= 1'b0;
      mepc_q    <= 32'd0;
      mtval_q   <= 32'd0;
      instret_q <= 32'd0;
    end else begin
      taken_q <= 1'b0;
      unique case (state_q)
        StRun: begin
          if (bus.en_i) begin
            if (misaligned) begin
              state_q <= StTrap;
              pc_q    <= TRAP_VECTOR;
              mepc_q  <= pc_q;
              mtval_q <= tgt;
            end else begin
              pc_q      <= tgt;
              instret_q <= instret_q + 32'd1;
              taken_q   <= redirect;
            end
          end
        end
        StTrap: begin
          // Retires are blocked here, including on the ack cycle itself.
          if (bus.trap_ack_i) begin
            state_q <= StRun;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  assign bus.pc_o       = pc_q;
  assign bus.pc_plus4_o = pc_q + 32'd4;
  assign bus.taken_o    = taken_q;
  assign bus.trap_o     = (state_q == StTrap);
  assign bus.mepc_o     = mepc_q;
  assign bus.mtval_o    = mtval_q;
  assign bus.instret_o  = instret_q;

endmodule

// File: doc/riscv_pc_unit.md
Name: riscv_pc_unit

Overview:
Program-counter and control-flow stage directly downstream of the ALU. Consumes the ALU result and branch flag for the instruction currently in execute, and computes and registers the next PC: sequential, conditional branch, JAL or JALR. Detects misaligned targets and enters a trap state that holds until acknowledged. Also provides the link value and a retired-instruction counter.

Parameters:
RESET_VECTOR  32'h0000_0000  PC value loaded on reset
TRAP_VECTOR   32'h0000_0100  PC value loaded on a misaligned-target trap

Ports:
clk_i         in   1   clock, all state updates on rising edge
rst_i         in   1   synchronous reset, active-high
en_i          in   1   current instruction retires this cycle; PC advances
branch_i      in   1   current instruction is a conditional branch (B-type)
jal_i         in   1   current instruction is JAL
jalr_i        in   1   current instruction is JALR
imm_i         in   32  sign-extended immediate for branch/JAL offset
alu_flag_i    in   1   ALU compare flag (branch condition true)
alu_result_i  in   32  ALU result (rs1+imm for JALR)
trap_ack_i    in   1   trap handler acknowledge; leaves TRAP state
pc_o          out  32  current PC (registered)
pc_plus4_o    out  32  pc_o+4 (combinational, link value for rd)
taken_o       out  1   1-cycle pulse: previous retire redirected the PC
trap_o        out  1   high while in TRAP state
mepc_o        out  32  PC of the instruction that faulted
mtval_o       out  32  offending misaligned target
instret_o     out  32  count of successfully retired instructions

Behaviour:
- Reset (rst_i=1 at edge, takes priority over everything): pc_o=RESET_VECTOR, state=RUN, taken_o=0, mepc_o=0, mtval_o=0, instret_o=0. trap_o=0 follows from the state. Reset mid-trap returns to RUN.
- States: RUN, TRAP. trap_o = (state==TRAP).
- RUN, en_i=0: all registers hold; taken_o<=0.
- RUN, en_i=1: target selection by priority jalr_i > jal_i > branch_i > sequential. Simultaneous selects resolve by this priority.
  - jalr: tgt = alu_result_i & 32'hFFFF_FFFE.
  - jal: tgt = pc_o + imm_i.
  - branch with alu_flag_i=1: tgt = pc_o + imm_i.
  - branch with alu_flag_i=0, or no control flow: tgt = pc_o + 4.
  - All additions are modulo 2^32 with no overflow detection. 32'hFFFF_FFFC+4 = 0.
- Redirect = jalr | jal | (branch & alu_flag_i).
- Misaligned: redirect and tgt[1:0]!=0. Sequential tgt is never checked.
  - On misaligned: pc_o<=TRAP_VECTOR, mepc_o<=pc_o, mtval_o<=tgt, state<=TRAP, instret_o unchanged, taken_o<=0.
  - Otherwise: pc_o<=tgt, instret_o<=instret_o+1 (wraps FFFF_FFFF->0), taken_o<=redirect.
- TRAP: en_i and all control inputs ignored; pc_o, mepc_o, mtval_o and instret_o hold; taken_o<=0.
  - trap_ack_i=1 -> state<=RUN next edge; pc_o stays TRAP_VECTOR.
  - en_i on the ack cycle is ignored. The first retire is allowed on the following cycle.
- trap_ack_i in RUN: no effect.
- Latency: 1 cycle from retire edge to new pc_o. taken_o is asserted in the same cycle that the new pc_o is visible.
- alu_flag_i is ignored unless branch_i is the selected source.

Test Plan:
- Reset, then 3 cycles en_i=1 with no control-flow selects -> pc_o 0,4,8,C; instret_o=3; taken_o never high.
- pc=0x20, branch_i=1, imm=0xFFFF_FFF0, flag=1 -> pc_o=0x10, taken_o pulses 1 cycle. Same stimulus with flag=0 -> pc_o=0x24, taken_o=0.
- pc=0x40, jalr_i=1, jal_i=1, branch_i=1, alu_result=0x1001 -> pc_o=0x1000 (jalr priority, bit0 cleared), pc_plus4_o=0x1004, instret_o increments.
- pc=0x80, jal_i=1, imm=0x6 -> trap_o=1, pc_o=0x100, mepc_o=0x80, mtval_o=0x86, instret_o unchanged. en_i pulses are ignored while in TRAP. trap_ack_i with en_i=1 -> RUN next cycle, pc_o=0x100. A retire on the next cycle -> pc_o=0x104.
- pc=0xFFFF_FFFC, en_i=1 sequential -> pc_o=0; instret_o preloaded to FFFF_FFFF via retires (or force) -> wraps to 0.
- Assert rst_i while in TRAP with en_i=1 -> next cycle pc_o=RESET_VECTOR, trap_o=0, instret_o=0, mepc_o=0.
